// File: rtl/capt_rd_ctrl_if.sv
// Capture FIFO byte read port plus the downstream valid/ready byte stream.
// master: the read sequencer (pops the FIFO, drives the stream).
// slave:  the environment (FIFO read side and stream sink).
interface capt_rd_ctrl_if;
    logic        cfifo_rd_vld;
    logic [11:0] cfifo_rd_cnt;
    logic [7:0]  cfifo_rd_data;
    logic        sob;
    logic        eob;
    logic        cfifo_rd_en;
    logic        out_vld;
    logic [7:0]  out_data;
    logic        out_rdy;
    logic        out_last;

    modport master (
        input  cfifo_rd_vld, cfifo_rd_cnt, cfifo_rd_data, sob, eob, out_rdy,
        output cfifo_rd_en, out_vld, out_data, out_last
    );

    modport slave (
        output cfifo_rd_vld, cfifo_rd_cnt, cfifo_rd_data, sob, eob, out_rdy,
        input  cfifo_rd_en, out_vld, out_data, out_last
    );
endinterface

// File: rtl/capt_rd_ctrl.sv
// capt_rd_ctrl: burst read sequencer for the capture FIFO (clk_reg domain).
// Drains up to burst_len bytes (stopping early on end-of-frame) from the
// FIFO read port into a valid/ready stream, drives checksum clear at frame
// start, resume-fill after frame end, and per-burst / per-frame status.
// Optional: define CAPT_RD_TIMEOUT_EN to release a partial burst (or fail
// an empty one) after WAIT_MAX cycles in WAIT.
module capt_rd_ctrl #(
    parameter int unsigned CLR_HOLD = 4,
    parameter int unsigned WAIT_MAX = 1024
) (
    input  logic           clk_reg,
    input  logic           rst,
    input  logic           burst_req,
    input  logic [11:0]    burst_len,
    output logic           burst_busy,
    output logic           burst_done,
    output logic           burst_eof,
    output logic           burst_err,
    output logic [11:0]    burst_xfer,
    capt_rd_ctrl_if.master cap,
    output logic           clr_chksm,
    output logic           resume_fill,
    output logic [15:0]    frame_cnt
);

    localparam int unsigned HOLD_W = (CLR_HOLD < 2) ? 1 : $clog2(CLR_HOLD + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STREAM,
        ST_DONE,
        ST_FEND
    } state_t;

    state_t            state, state_nxt;
    logic [11:0]       rem;
    logic [11:0]       xfer_q;
    logic              eof_q, err_q;
    logic [15:0]       frame_q;
    logic [HOLD_W-1:0] hold_cnt;

    logic accept, zero_req, xfer_hit, part_ld, tmo_err;

`ifdef CAPT_RD_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(WAIT_MAX + 1);
    logic [TMR_W-1:0] timer;
    logic             tmo_hit;
    assign tmo_hit = (timer == TMR_W'(WAIT_MAX - 1));
`endif

    // State register.
    always_ff @(posedge clk_reg) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode, stream/status outputs and datapath strobes.
    always_comb begin
        state_nxt       = state;
        accept          = 1'b0;
        zero_req        = 1'b0;
        xfer_hit        = 1'b0;
        part_ld         = 1'b0;
        tmo_err         = 1'b0;
        burst_busy      = (state != ST_IDLE);
        burst_done      = 1'b0;
        burst_eof       = 1'b0;
        burst_err       = 1'b0;
        resume_fill     = 1'b0;
        cap.out_vld     = 1'b0;
        cap.out_data    = '0;
        cap.cfifo_rd_en = 1'b0;
        cap.out_last    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (burst_req) begin
                    if (burst_len == '0) begin
                        zero_req  = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cap.cfifo_rd_cnt >= rem) begin
                    state_nxt = ST_STREAM;
`ifdef CAPT_RD_TIMEOUT_EN
                end else if (tmo_hit) begin
                    if (cap.cfifo_rd_cnt != '0) begin
                        part_ld   = 1'b1;
                        state_nxt = ST_STREAM;
                    end else begin
                        tmo_err   = 1'b1;
                        state_nxt = ST_DONE;
                    end
`endif
                end
            end
            ST_STREAM: begin
                // Stream is gated during reset so no byte is popped on the reset edge.
                if (!rst) begin
                    cap.out_vld     = cap.cfifo_rd_vld;
                    cap.out_data    = cap.cfifo_rd_data;
                    cap.cfifo_rd_en = cap.cfifo_rd_vld & cap.out_rdy;
                    cap.out_last    = cap.cfifo_rd_vld & ((rem == 12'd1) | cap.eob);
                    xfer_hit        = cap.cfifo_rd_vld & cap.out_rdy;
                end
                if (xfer_hit && (cap.eob || rem == 12'd1)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                burst_done = 1'b1;
                burst_eof  = eof_q;
                burst_err  = err_q;
                state_nxt  = eof_q ? ST_FEND : ST_IDLE;
            end
            ST_FEND: begin
                resume_fill = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Burst bookkeeping: remaining count, bytes moved, status flags, frames.
    always_ff @(posedge clk_reg) begin
        if (rst) begin
            rem     <= '0;
            xfer_q  <= '0;
            eof_q   <= 1'b0;
            err_q   <= 1'b0;
            frame_q <= '0;
        end else begin
            if (accept) begin
                rem    <= burst_len;
                xfer_q <= '0;
                eof_q  <= 1'b0;
                err_q  <= 1'b0;
            end
            if (zero_req) begin
                xfer_q <= '0;
                eof_q  <= 1'b0;
                err_q  <= 1'b1;
            end
            if (part_ld) rem   <= cap.cfifo_rd_cnt;
            if (tmo_err) err_q <= 1'b1;
            if (xfer_hit) begin
                rem    <= rem - 12'd1;
                xfer_q <= xfer_q + 12'd1;
                if (cap.eob) begin
                    eof_q   <= 1'b1;
                    frame_q <= frame_q + 16'd1;
                end
            end
        end
    end

    // Checksum-clear hold: reloads on every sob byte, independent of state.
    always_ff @(posedge clk_reg) begin
        if (rst)                   hold_cnt <= '0;
        else if (xfer_hit && cap.sob) hold_cnt <= HOLD_W'(CLR_HOLD);
        else if (hold_cnt != '0)   hold_cnt <= hold_cnt - HOLD_W'(1);
    end

`ifdef CAPT_RD_TIMEOUT_EN
    // WAIT timer: cleared on request acceptance, counts each WAIT cycle.
    always_ff @(posedge clk_reg) begin
        if (rst || accept)        timer <= '0;
        else if (state == ST_WAIT) timer <= timer + TMR_W'(1);
    end
`endif

    assign clr_chksm  = (hold_cnt != '0);
    assign burst_xfer = xfer_q;
    assign frame_cnt  = frame_q;

endmodule
